// File: rtl/uart_tx_drain.sv
// uart_tx_drain
//   Drains bytes from the transmit-side uart_fifo and serialises them onto the
//   TX pin as 8N1 frames (start, WIDTH data bits LSB first, stop). One FIFO
//   read is issued per frame. The read data is captured one cycle later, when
//   the FIFO reports it valid.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH        - data bits per frame (matches the FIFO WIDTH)
//   CLKS_PER_BIT - i_clk cycles per UART bit, >= 2
//
// Ports:
//   i_clk      - clock
//   i_rst      - asynchronous active-high reset
//   o_rd_en    - FIFO read strobe (combinational, only in IDLE)
//   i_rd_data  - FIFO read data
//   i_rd_valid - FIFO read data valid, one cycle after an accepted read
//   i_empty    - FIFO empty flag
//   o_tx       - serial line, idle high
//   o_busy     - high whenever not IDLE
//   o_done     - one-cycle pulse in the first IDLE cycle after a stop bit
module uart_tx_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_rd_en,
    input  logic [WIDTH-1:0] i_rd_data,
    input  logic             i_rd_valid,
    input  logic             i_empty,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     baud_cnt;
    logic [IW-1:0]     bit_idx;
    logic [WIDTH-1:0]  shift;
    logic              done_q;
    logic              bit_end;
    logic              timed;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    assign bit_end = (baud_cnt == CNT_MAX);

    // States in which the baud counter runs
    always_comb begin
        timed = 1'b0;
        case (state)
            S_START, S_DATA, S_STOP: timed = 1'b1;
`ifdef UART_TX_PARITY_EN
            S_PARITY:                timed = 1'b1;
`endif
            default:                 timed = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!i_empty) state_nxt = S_WAIT;
            S_WAIT:  state_nxt = i_rd_valid ? S_START : S_IDLE;
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA: begin
                if (bit_end && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
            S_STOP:  if (bit_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: baud counter, bit index, shift register, done pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // Cleared on every state change and at each bit boundary, so the
            // count never leaves 0..CLKS_PER_BIT-1.
            if (!timed || bit_end || (state_nxt != state))
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + CW'(1);

            if (state != S_DATA)
                bit_idx <= '0;
            else if (bit_end)
                bit_idx <= bit_idx + IW'(1);

            if ((state == S_WAIT) && i_rd_valid) begin
                shift    <= i_rd_data;
`ifdef UART_TX_PARITY_EN
                parity_q <= ^i_rd_data;
`endif
            end else if ((state == S_DATA) && bit_end) begin
                shift <= shift >> 1;
            end

            done_q <= (state == S_STOP) && bit_end;
        end
    end

    // Outputs; o_tx is decoded from state so reset forces the line high at once
    always_comb begin
        o_tx    = 1'b1;
        o_rd_en = (state == S_IDLE) && !i_empty;
        o_busy  = (state != S_IDLE);
        o_done  = done_q;
        case (state)
            S_START:  o_tx = 1'b0;
            S_DATA:   o_tx = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: o_tx = parity_q;
`endif
            default:  o_tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
module tb_uart_tx_drain;

    localparam int CPB = 4;
    localparam int W   = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    // {stop, parity, data, start}; parity = even parity of the data byte
    localparam logic [10:0] F41 = {1'b1, 1'b0, 8'h41, 1'b0};
    localparam logic [10:0] F43 = {1'b1, 1'b1, 8'h43, 1'b0};
    localparam logic [10:0] F61 = {1'b1, 1'b1, 8'h61, 1'b0};
    localparam logic [10:0] F62 = {1'b1, 1'b1, 8'h62, 1'b0};
`else
    localparam int NB = 10;
    // {pad, stop, data, start}
    localparam logic [10:0] F41 = {1'b0, 1'b1, 8'h41, 1'b0};
    localparam logic [10:0] F61 = {1'b0, 1'b1, 8'h61, 1'b0};
    localparam logic [10:0] F62 = {1'b0, 1'b1, 8'h62, 1'b0};
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_en;
    logic [W-1:0] rd_data = '0;
    logic         rd_valid;
    logic         empty;
    logic         tx;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    uart_tx_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .o_rd_en    (rd_en),
        .i_rd_data  (rd_data),
        .i_rd_valid (rd_valid),
        .i_empty    (empty),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_done     (done)
    );

    // Behavioural FIFO: registered read, valid one cycle after the strobe
    logic [7:0] mem [0:63];
    int         wp = 0;
    int         rp = 0;
    logic       novalid = 1'b0;

    assign empty = (wp == rp);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_en && (wp != rp)) begin
                rd_data  <= mem[rp];
                rp       <= rp + 1;
                rd_valid <= !novalid;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 1;
    endtask

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    int done_cnt = 0;
    int rd_cnt   = 0;
    always @(negedge clk) begin
        if (done)  done_cnt <= done_cnt + 1;
        if (rd_en) rd_cnt   <= rd_cnt + 1;
    end

    // Scoreboard monitor: decodes each frame off the line and compares it
    // with the next expected frame.
    logic [10:0] exp_q [$];
    logic        smp [0:NB*CPB-1];
    logic [10:0] got_f;
    logic [10:0] exp_f;
    logic        stable, busy_ok, aborted;
    int          hi_cnt   = 0;
    int          last_gap = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hi_cnt = 0;
            end else if (tx === 1'b1) begin
                hi_cnt++;
            end else begin
                last_gap = hi_cnt;
                aborted  = 1'b0;
                busy_ok  = busy;
                smp[0]   = tx;
                for (int i = 1; i < NB*CPB; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i]  = tx;
                    busy_ok = busy_ok & busy;
                end
                if (aborted) begin
                    hi_cnt = 0;
                end else begin
                    got_f  = '0;
                    stable = 1'b1;
                    for (int k = 0; k < NB; k++) begin
                        got_f[k] = smp[k*CPB];
                        for (int j = 1; j < CPB; j++)
                            if (smp[k*CPB+j] !== smp[k*CPB]) stable = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got %0h expected no frame", got_f);
                    end else begin
                        exp_f = exp_q.pop_front();
                        check("frame_bits", got_f, exp_f);
                    end
                    check("bit_hold", stable, 1);
                    check("busy_in_frame", busy_ok, 1);
                    @(negedge clk);
                    check("done_timing", done, 1);
                    hi_cnt = 1;
                end
            end
        end
    end

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (done_cnt >= target), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  d0, r0, n;
    logic ok;

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte
        d0 = done_cnt; r0 = rd_cnt;
        exp_q.push_back(F41);
        push(8'h41);
        wait_done(d0 + 1, 40*CPB, "t1_done_seen");
        repeat (3) @(negedge clk);
        check("t1_rd_pulses", rd_cnt - r0, 1);
        check("t1_done_pulses", done_cnt - d0, 1);

        // Back-to-back
        d0 = done_cnt; r0 = rd_cnt;
        exp_q.push_back(F61);
        exp_q.push_back(F62);
        push(8'h61);
        push(8'h62);
        wait_done(d0 + 2, 80*CPB, "t2_done_seen");
        repeat (3) @(negedge clk);
        check("t2_gap", last_gap, 2);
        check("t2_rd_pulses", rd_cnt - r0, 2);
        check("t2_done_pulses", done_cnt - d0, 2);

        // Empty FIFO
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check("t3_idle", ok, 1);

        // Missing valid
        d0 = done_cnt;
        novalid = 1'b1;
        push(8'h5a);
        #1;
        check("t4_rd_en", rd_en, 1);
        @(negedge clk);
        check("t4_wait_busy", busy, 1);
        @(negedge clk);
        check("t4_back_idle", busy, 0);
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || rd_en !== 1'b0) ok = 1'b0;
        end
        check("t4_line_idle", ok, 1);
        check("t4_no_done", done_cnt - d0, 0);
        novalid = 1'b0;

        // Reset mid-frame, during data bit 3
        d0 = done_cnt;
        push(8'h55);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_start_seen", tx, 0);
        repeat (4*CPB + 1) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) ok = 1'b0;
        end
        check("t5_idle_after", ok, 1);
        check("t5_no_done", done_cnt - d0, 0);

`ifdef UART_TX_PARITY_EN
        // Parity frames, 44 cycles each (checked by the monitor)
        d0 = done_cnt;
        exp_q.push_back(F41);
        exp_q.push_back(F43);
        push(8'h41);
        push(8'h43);
        wait_done(d0 + 2, 90*CPB, "t6_done_seen");
        repeat (3) @(negedge clk);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serializing UART transmitter that drains bytes from the transmit-side `uart_fifo` and drives the serial TX line. It sits between the case-converter datapath's output FIFO and the board TX pin. It issues single-cycle FIFO read strobes, captures the registered read data one cycle later, and shifts each byte out as a standard 8N1 frame.

## Interface

Parameters:
- `WIDTH`, default 8: data bits per frame; must match the FIFO `WIDTH`.
- `CLKS_PER_BIT`, default 868: `i_clk` cycles per UART bit (100 MHz / 115200). Must be ≥ 2.

Ports:
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset, asynchronous, active-high.
- `o_rd_en`, output, 1: FIFO read strobe; combinational.
- `i_rd_data`, input, WIDTH: FIFO read data.
- `i_rd_valid`, input, 1: FIFO read-data-valid, high one cycle after an accepted read.
- `i_empty`, input, 1: FIFO empty flag.
- `o_tx`, output, 1: serial line; idle high.
- `o_busy`, output, 1: high whenever the state is not IDLE.
- `o_done`, output, 1: one-cycle pulse after each completed stop bit.

## Operation

- States are IDLE, WAIT, START, DATA, PARITY (macro only), and STOP.
- **IDLE:**
  - `o_tx` = 1.
  - `o_rd_en` = (state==IDLE) && !`i_empty`.
  - If `o_rd_en` is high, go to WAIT next cycle; otherwise stay in IDLE.
- **WAIT:**
  - If `i_rd_valid` is high, latch `i_rd_data` into the shift register and go to START.
  - Otherwise go to IDLE; no frame is sent and no `o_done` is produced.
- **START:** `o_tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `o_tx` = shift[0], LSB first.
  - Each bit is held for `CLKS_PER_BIT` cycles.
  - The bit index counts 0..WIDTH-1; after bit WIDTH-1, go to PARITY (if enabled) or STOP.
- **STOP:** `o_tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE. `o_done` is high in the first cycle of IDLE.
- **Baud counter:**
  - Width `$clog2(CLKS_PER_BIT)`.
  - Clears on every state entry and counts 0..`CLKS_PER_BIT`-1.
  - A bit ends when the count reaches `CLKS_PER_BIT`-1; there is no wrap outside that range.
- **Bit index:** width `$clog2(WIDTH)+1`; clears on entry to DATA.
- `o_rd_en` is never asserted outside IDLE, so at most one outstanding FIFO read exists at any time.
- A FIFO write arriving during a frame does not affect the frame in progress. It is picked up at the next IDLE.

## Timing

- **Reset values:** `o_tx`=1, `o_rd_en`=0, `o_busy`=0, `o_done`=0, state=IDLE, counters=0.
- **Reset assertion mid-frame:** `o_tx` goes to 1 asynchronously and the byte is discarded. Data already read from the FIFO is lost.
- **Latency:** `o_rd_en` cycle → WAIT (valid) → first START cycle. The start bit begins 2 cycles after the `o_rd_en` cycle.
- **Frame length:** (WIDTH+2)·`CLKS_PER_BIT` cycles of line activity.
- **Back-to-back bytes:** `o_tx` stays high for exactly 2 cycles between the end of a stop bit and the next start bit. These are the IDLE cycle (with `o_done`=1 and `o_rd_en`=1) and the WAIT cycle.
- **Throughput:** one byte per (WIDTH+2)·`CLKS_PER_BIT`+2 cycles.
- **`i_empty` rising in the same cycle as IDLE entry:** no read is issued.
- `o_busy` is high from the WAIT cycle through the last STOP cycle.

## Configuration

- Macro: `UART_TX_PARITY_EN`.
- **Defined:**
  - A PARITY state follows DATA.
  - `o_tx` = even parity (XOR of all data bits) for `CLKS_PER_BIT` cycles.
  - Frame length is (WIDTH+3)·`CLKS_PER_BIT`.
- **Undefined:** no PARITY state, giving an 8N1 frame.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and WIDTH=8, with a behavioural `uart_fifo` model (registered read, valid one cycle later).

1. **Single byte.** Push 0x41. Required response:
   - `o_rd_en` pulses once.
   - `o_tx` shows 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles.
   - `o_done` pulses once, 40 cycles after the start-bit edge.
2. **Back-to-back.** Push 0x61 then 0x62. Required response:
   - Two frames: LSB-first 1,0,0,0,0,1,1,0 and 0,1,0,0,0,1,1,0.
   - Exactly 2 high cycles between frames.
   - Two `o_done` pulses.
3. **Empty FIFO.** Hold `i_empty`=1 for 100 cycles. Required: `o_rd_en`=0, `o_tx`=1, `o_busy`=0 throughout.
4. **Missing valid.** Force `i_rd_valid`=0 in WAIT. Required:
   - Return to IDLE next cycle.
   - `o_tx` never goes low.
   - No `o_done`.
5. **Reset mid-frame.** Assert `i_rst` during data bit 3 of 0x55. Required:
   - `o_tx`=1 immediately; `o_busy`=0.
   - After release with the FIFO empty, the line stays idle.
6. **`UART_TX_PARITY_EN` defined.** Send 0x41, then 0x43. Required:
   - Parity bit 0 for 0x41 and 1 for 0x43.
   - Each frame is 44 cycles.
